calc_tx_serializer: RTL and testbench

//  Serial output stage of the binary calculator, directly downstream of the Controller.
//  - Start: the Controller's TxData request.
//  - Function: captures the ALU result word and its flag nibble as one frame and shifts it out one bit per clock.
//  - Completion: returns TxDone, which closes the Controller's transmit phase (4-phase handshake).

---
 rtl/calc_tx_serializer_if.sv | 23 ++
 rtl/calc_tx_serializer.sv | 80 ++++++++
 tb/tb_calc_tx_serializer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/calc_tx_serializer_if.sv
// Controller <-> serializer transmit port: 4-phase TxData/TxDone handshake plus the serial bit stream.
interface calc_tx_serializer_if #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4
);
  logic              TxData;
  logic [DATA_W-1:0] Result;
  logic [FLAG_W-1:0] Flag;
  logic              DataOut;
  logic              OutValid;
  logic              TxBusy;
  logic              TxDone;

  modport master (
    output TxData, Result, Flag,
    input  DataOut, OutValid, TxBusy, TxDone
  );

  modport slave (
    input  TxData, Result, Flag,
    output DataOut, OutValid, TxBusy, TxDone
  );
endinterface

// File: rtl/calc_tx_serializer.sv
// Serial output stage: captures {Flag,Result} on TxData and shifts it out MSB-first, one bit per clock.
// Build option TX_PARITY_EN appends an even-parity bit after Result[0].
module calc_tx_serializer #(
  parameter int DATA_W = 8,
  parameter int FLAG_W = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  calc_tx_serializer_if.slave   tx
);
  localparam int FRAME_W = DATA_W + FLAG_W;
`ifdef TX_PARITY_EN
  localparam int NBITS = FRAME_W + 1;
`else
  localparam int NBITS = FRAME_W;
`endif
  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [NBITS-1:0] frame_load;

`ifdef TX_PARITY_EN
  assign frame_load = {tx.Flag, tx.Result, ^{tx.Flag, tx.Result}};
`else
  assign frame_load = {tx.Flag, tx.Result};
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tx.OutValid = 1'b0;
    tx.TxBusy   = 1'b0;
    tx.TxDone   = 1'b0;
    case (state)
      IDLE: if (tx.TxData) state_nxt = SEND;
      SEND: begin
        tx.OutValid = 1'b1;
        tx.TxBusy   = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        tx.TxBusy = 1'b1;
        tx.TxDone = 1'b1;
        if (!tx.TxData) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Zero fill means the register is already clear once the last bit has left,
  // so DataOut reads 0 in DONE/IDLE without extra gating.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (tx.TxData) begin
          shreg <= frame_load;
          cnt   <= CNT_W'(NBITS - 1);
        end
        SEND: begin
          shreg <= shreg << 1;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign tx.DataOut = shreg[NBITS-1];
endmodule

// File: tb/tb_calc_tx_serializer.sv
// Randomized bench for calc_tx_serializer against a frame-level reference model.
module tb_calc_tx_serializer;
  localparam int DATA_W  = 8;
  localparam int FLAG_W  = 4;
  localparam int FRAME_W = DATA_W + FLAG_W;
`ifdef TX_PARITY_EN
  localparam int NBITS = FRAME_W + 1;
`else
  localparam int NBITS = FRAME_W;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  calc_tx_serializer_if #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) bus ();
  calc_tx_serializer #(.DATA_W(DATA_W), .FLAG_W(FLAG_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .tx    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Frame k: payload bits MSB-first, then even parity over the payload (if built in).
  function automatic logic ref_bit(input logic [7:0] r, input logic [3:0] f, input int k);
    int payload;
    payload = int'(f) * 256 + int'(r);
    if (k < FRAME_W) return logic'((payload >> (FRAME_W - 1 - k)) & 1);
    return logic'($countones(payload) % 2);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, bus.OutValid, 0);
    chk({tag, "_busy"},  bus.TxBusy,   0);
    chk({tag, "_done"},  bus.TxDone,   0);
    chk({tag, "_data"},  bus.DataOut,  0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      check_idle("idle");
    end
  endtask

  // Runs one frame; inputs after capture are scrambled (or set to chg_val in cycle chg_cyc).
  task automatic run_frame(input logic [7:0] r, input logic [3:0] f, input int hold,
                           input int chg_cyc, input logic [7:0] chg_val, input bit scr);
    @(negedge Clk);
    bus.Result = r;
    bus.Flag   = f;
    bus.TxData = 1'b1;
    @(posedge Clk); #1;
    for (int k = 0; k < NBITS; k++) begin
      chk("send_valid", bus.OutValid, 1);
      chk("send_busy",  bus.TxBusy,   1);
      chk("send_done",  bus.TxDone,   0);
      chk($sformatf("bit%0d_%02h_%01h", k, r, f), bus.DataOut, ref_bit(r, f, k));
      @(negedge Clk);
      if (k == chg_cyc) bus.Result = chg_val;
      else if (scr) bus.Result = 8'($urandom);
      if (scr) bus.Flag = 4'($urandom);
      @(posedge Clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_flag",  bus.TxDone,   1);
      chk("done_busy",  bus.TxBusy,   1);
      chk("done_valid", bus.OutValid, 0);
      chk("done_data",  bus.DataOut,  0);
      if (h < hold) begin
        @(posedge Clk); #1;
      end
    end
    @(negedge Clk);
    bus.TxData = 1'b0;
    @(posedge Clk); #1;
    check_idle("exit");
  endtask

  initial begin
    bus.TxData = 1'b0;
    bus.Result = '0;
    bus.Flag   = '0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #10;
    check_idle("reset");
    @(negedge Clk) Reset = 1'b1;
    idle_cycles(2);

    run_frame(8'hA5, 4'h3, 0, -1, 8'h00, 1'b0);   // basic frame
    idle_cycles(2);
    run_frame(8'h01, 4'h0, 0, -1, 8'h00, 1'b0);   // parity source = 1
    idle_cycles(1);
    run_frame(8'h00, 4'h0, 0, 3, 8'hFF, 1'b0);    // capture isolation
    idle_cycles(1);
    run_frame(8'h5A, 4'hC, 5, -1, 8'h00, 1'b1);   // long hold, no retrigger
    run_frame(8'h3C, 4'h9, 0, -1, 8'h00, 1'b1);   // back-to-back
    idle_cycles(3);

    // Reset in cycle 6 of a frame: frame dropped, no TxDone afterwards.
    @(negedge Clk);
    bus.Result = 8'hC3;
    bus.Flag   = 4'hA;
    bus.TxData = 1'b1;
    @(posedge Clk); #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rst_bit%0d", k), bus.DataOut, ref_bit(8'hC3, 4'hA, k));
      @(posedge Clk); #1;
    end
    #2 Reset = 1'b0;
    #1 check_idle("rst_async");
    @(negedge Clk);
    bus.TxData = 1'b0;
    @(negedge Clk) Reset = 1'b1;
    idle_cycles(16);

    for (int i = 0; i < 25; i++) begin
      run_frame(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)), -1, 8'h00, 1'b1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
